// File: rtl/div_pkg.sv
// Shared types for the iterative divider: operation encoding and FSM states.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // DIV and REM interpret operands as two's complement.
  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/restoring_step.sv
// One radix-2 restoring division step: shift {rem, quo} left and try to
// subtract the divisor magnitude from the widened partial remainder.
module restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           borrow;

  // Since rem < divisor_mag, the shifted remainder fits in WIDTH+1 bits and
  // the MSB of the WIDTH+1-bit difference is exactly the borrow.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor_mag};
    borrow   = trial[WIDTH];
    quo_next = {quo[WIDTH-2:0], ~borrow};
    rem_next = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. The FSM runs
// IDLE -> CALC (WIDTH steps) -> FIX (sign correction) -> DONE; divide-by-zero
// and signed overflow bypass straight from IDLE to DONE.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_nxt;
  div_op_e          op_in, op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] rem_step, quo_step;

  logic             accept, sgn, div_zero, ovf, special;
  logic [WIDTH-1:0] special_res, a_mag, b_mag, q_fix, r_fix;

  restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dvs_q),
    .rem_next    (rem_step),
    .quo_next    (quo_step)
  );

  // Accept-time decode: special-case detection, operand magnitudes and the
  // sign-corrected outputs used in FIX.
  always_comb begin
    op_in       = div_op_e'(op);
    accept      = (state == S_IDLE) && start;
    sgn         = is_signed_op(op_in);
    div_zero    = (divisor == '0);
    ovf         = sgn && (dividend == MIN_VAL) && (divisor == '1);
    special     = div_zero || ovf;
    if (is_rem_op(op_in))
      special_res = div_zero ? dividend : '0;
    else
      special_res = div_zero ? '1 : dividend;
    // The most negative value negates to itself, which read unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    a_mag       = (sgn && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    b_mag       = (sgn && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    q_fix       = neg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix       = neg_r ? (~rem_q + 1'b1) : rem_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture at accept, one step per CALC cycle, result
  // written only in FIX or on a special-case accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_DIV;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            cnt   <= CW'(WIDTH - 1);
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            neg_q <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn && dividend[WIDTH-1];
            if (special) result <= special_res;
          end
        end
        S_CALC: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          result <= is_rem_op(op_q) ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected result and
// done cycle; a monitor pops and compares on every done pulse.
module tb_iter_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] result;

  iter_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;
  exp_t scb[$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: plain wide integer division; RISC-V semantics for /0.
  function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sbv, q, r;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0]) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'b0, a});
      sbv = longint'({32'b0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return o[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (b == '0) return 1;
    if (!o[0] && a == MINV && b == '1) return 1;
    return W + 2;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (scb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = scb.pop_front();
        check("result", result, e.res);
        check("done_cycle", W'(cyc), W'(e.at));
      end
    end
  end

  // Called at a negedge while the DUT is idle; start stays high for one edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    op = o; dividend = a; divisor = b; start = 1'b1;
    e.res = ref_div(o, a, b);
    e.at  = cyc + ref_lat(o, a, b);
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", k);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    int sel;
    rst = 1'b1; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", W'(busy), '0);

    // DIVU 100/7 with busy profile; an extra start in cycle 5 must be ignored.
    issue(2'd1, 32'd100, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      check("busy_window", W'(busy), W'(1));
      if (k == 5) begin
        op = 2'd1; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    check("busy_after_done", W'(busy), '0);

    // Start in the IDLE cycle right after done; result holds 14 meanwhile.
    issue(2'd0, 32'hFFFF_FFF9, 32'd2);
    repeat (8) @(negedge clk);
    check("result_hold", result, 32'd14);
    wait_done();
    // Start raised during DONE is ignored and accepted in the next IDLE cycle.
    op = 2'd2; dividend = 32'hFFFF_FFF9; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    issue(2'd1, 32'h1234, 32'd0);
    wait_idle();
    issue(2'd3, 32'h1234, 32'd0);
    wait_idle();
    issue(2'd0, MINV, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'd2, MINV, 32'hFFFF_FFFF);
    wait_idle();

    // Reset in the middle of CALC.
    issue(2'd1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_result", result, '0);
    scb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'd1, 32'd9, 32'd3);
    wait_idle();

    // Randomized operations mixed with boundary operands.
    repeat (48) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = MINV; b = '1; end
        2: b = W'($urandom_range(1, 15));
        3: begin a = MINV; b = W'($urandom_range(1, 3)); end
        4: b = '1;
        default: ;
      endcase
      issue(2'($urandom_range(0, 3)), a, b);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(scb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
